vector_lsu: RTL and testbench
=============================

# vector_lsu

Vector load/store controller that initiates all accesses to the vector data memory on behalf of the MEM pipeline stage. Accepts one vector load or store request at a time over a valid/ready handshake and sequences the memory's write-enable, address and write-data lines. Captures the registered read data and returns it over a held response handshake. Optional per-lane masked stores are implemented as read-modify-write.

## Interface
Parameters:
- dataSize, 32, bits per vector lane
- addressingSize, 32, address width
- vecSize, 4, lanes per vector

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_addr  in  addressingSize  vector base byte address, passed to memory unchanged
- req_wdata  in  vecSize x dataSize  store data, lane i at [i]
- req_mask  in  vecSize  per-lane store enable; used only when VLSU_MASKED_STORE_EN is defined
- resp_valid  out  1  response held until accepted
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  vecSize x dataSize  load data; all zeros for stores
- busy  out  1  high in every state except IDLE
- mem_write_enable  out  1  to memory write enable
- mem_data_adr  out  addressingSize  to memory address
- mem_to_write_data  out  vecSize x dataSize  to memory write data
- mem_read_data  in  vecSize x dataSize  from memory; registered, valid the cycle after an address is presented with write enable low

## Operation
- States: IDLE, READ, CAPTURE, WRITE, RESP.
- Accept on the rising edge with req_valid && req_ready. At that edge, register req_write, req_addr, req_wdata and req_mask. mem_data_adr takes the registered address.
- Load: IDLE -> READ -> CAPTURE -> RESP.
  - In CAPTURE, register mem_read_data into resp_rdata.
- Full store (mask ignored, or mask all ones): IDLE -> WRITE -> RESP.
- Masked store, macro defined and mask neither all ones nor all zeros: IDLE -> READ -> CAPTURE -> WRITE -> RESP.
  - CAPTURE latches the old vector.
  - In WRITE, lane i = req_mask[i] ? new lane i : old lane i.
- Masked store with all-zero mask: IDLE -> RESP directly. No memory write.
- mem_write_enable is high only in WRITE, for exactly one cycle per store.
- RESP: resp_valid high; resp_rdata stable. On resp_valid && resp_ready, go to IDLE.
- mem_data_adr holds its last value outside active states. The memory reads continuously with write enable low; this is harmless.
- No range or alignment checking. Address validity is the requester's responsibility.

## Timing
- Reset values: req_ready 1, resp_valid 0, resp_rdata 0, busy 0, mem_write_enable 0, mem_data_adr 0, mem_to_write_data 0; state IDLE.
- Reset assertion mid-operation forces IDLE and drops mem_write_enable immediately (asynchronous). Any in-flight write cycle is aborted.
- Latency, in cycles from the accept edge to resp_valid high:
  - Load: 3.
  - Full store: 2.
  - Masked store: 4.
  - All-zero-mask store: 1.
- resp_ready low: hold RESP indefinitely; resp_rdata must not change.
- Back-to-back requests: req_ready returns high in the cycle after the response handshake. Minimum one idle cycle between requests.
- req_valid while busy is ignored. The requester must hold its request until it sees req_ready.

## Configuration
- VLSU_MASKED_STORE_EN defined:
  - req_mask honoured through the read-modify-write path.
  - CAPTURE is reused for stores.
- VLSU_MASKED_STORE_EN not defined:
  - req_mask unused.
  - Every store is a full store.
  - The merge logic and the store path through READ/CAPTURE are not synthesized.

## Structure
- Package vlsu_pkg holds:
  - the state enum type vlsu_state_t;
  - default lane-count and width constants shared with the data memory instantiation.
- One sub-module, vlsu_lane_merge: combinational per-lane select of new vs old data by mask. Instantiated only under VLSU_MASKED_STORE_EN.

## Test plan
- Reset then load at 0x10 with memory lanes {0x11111111, 0x22222222, 0x33333333, 0x44444444} -> resp_valid 3 cycles after accept with identical lanes; mem_write_enable never high.
- Full store {0xA, 0xB, 0xC, 0xD} to 0x20 -> mem_write_enable high exactly one cycle, address 0x20; a following load returns {0xA, 0xB, 0xC, 0xD}.
- Macro on, store {0xFF, 0xFF, 0xFF, 0xFF} with mask 4'b0101 over {1, 2, 3, 4} -> memory holds {0xFF, 2, 0xFF, 4}; resp after 4 cycles.
- Load with resp_ready held low 5 cycles -> resp_valid and resp_rdata stable throughout; req_ready low until handshake; req_valid pulses meanwhile ignored.
- Macro on, mask 4'b0000 store -> resp_valid 1 cycle after accept; no write cycle.
- rst_n asserted during WRITE -> mem_write_enable low immediately; after release all outputs at reset values and req_ready 1.

Source files
------------

// File: rtl/vlsu_pkg.sv
// Shared types and default geometry for the vector load/store unit.
// Geometry constants are also used by the data memory instantiation.
package vlsu_pkg;

  localparam int VLSU_DATA_W = 32;
  localparam int VLSU_ADDR_W = 32;
  localparam int VLSU_LANES  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } vlsu_state_t;

endpackage

// File: rtl/vlsu_lane_merge.sv
// Per-lane select of new store data vs old memory data.
// Used by the read-modify-write masked store path.
module vlsu_lane_merge
  import vlsu_pkg::*;
#(
  parameter int dataSize = VLSU_DATA_W,
  parameter int vecSize  = VLSU_LANES
) (
  input  logic [vecSize-1:0]               mask,
  input  logic [vecSize-1:0][dataSize-1:0] new_data,
  input  logic [vecSize-1:0][dataSize-1:0] old_data,
  output logic [vecSize-1:0][dataSize-1:0] merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < vecSize; i++) begin
      if (mask[i]) merged[i] = new_data[i];
    end
  end

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store sequencer for the MEM stage data memory.
// VLSU_MASKED_STORE_EN enables per-lane masked stores via read-modify-write.
module vector_lsu
  import vlsu_pkg::*;
#(
  parameter int dataSize       = VLSU_DATA_W,
  parameter int addressingSize = VLSU_ADDR_W,
  parameter int vecSize        = VLSU_LANES
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [addressingSize-1:0]         req_addr,
  input  logic [vecSize-1:0][dataSize-1:0]  req_wdata,
  input  logic [vecSize-1:0]                req_mask,
  output logic                              resp_valid,
  input  logic                              resp_ready,
  output logic [vecSize-1:0][dataSize-1:0]  resp_rdata,
  output logic                              busy,
  output logic                              mem_write_enable,
  output logic [addressingSize-1:0]         mem_data_adr,
  output logic [vecSize-1:0][dataSize-1:0]  mem_to_write_data,
  input  logic [vecSize-1:0][dataSize-1:0]  mem_read_data
);

  vlsu_state_t state;

`ifdef VLSU_MASKED_STORE_EN
  logic                             wr_q;
  logic [vecSize-1:0]               mask_q;
  logic [vecSize-1:0][dataSize-1:0] wdata_q;
  logic [vecSize-1:0][dataSize-1:0] merged;

  vlsu_lane_merge #(
    .dataSize (dataSize),
    .vecSize  (vecSize)
  ) u_merge (
    .mask     (mask_q),
    .new_data (wdata_q),
    .old_data (mem_read_data),
    .merged   (merged)
  );
`else
  logic unused_mask;
  assign unused_mask = ^req_mask;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      req_ready         <= 1'b1;
      busy              <= 1'b0;
      resp_valid        <= 1'b0;
      resp_rdata        <= '0;
      mem_write_enable  <= 1'b0;
      mem_data_adr      <= '0;
      mem_to_write_data <= '0;
`ifdef VLSU_MASKED_STORE_EN
      wr_q              <= 1'b0;
      mask_q            <= '0;
      wdata_q           <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            mem_data_adr <= req_addr;
            resp_rdata   <= '0;
            req_ready    <= 1'b0;
            busy         <= 1'b1;
`ifdef VLSU_MASKED_STORE_EN
            wr_q    <= req_write;
            mask_q  <= req_mask;
            wdata_q <= req_wdata;
            if (!req_write) begin
              state <= S_READ;
            end else if (~|req_mask) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
            end else if (!(&req_mask)) begin
              state <= S_READ;
            end else begin
              state             <= S_WRITE;
              mem_write_enable  <= 1'b1;
              mem_to_write_data <= req_wdata;
            end
`else
            if (!req_write) begin
              state <= S_READ;
            end else begin
              state             <= S_WRITE;
              mem_write_enable  <= 1'b1;
              mem_to_write_data <= req_wdata;
            end
`endif
          end
        end
        S_READ: begin
          state <= S_CAPTURE;
        end
        S_CAPTURE: begin
`ifdef VLSU_MASKED_STORE_EN
          if (wr_q) begin
            state             <= S_WRITE;
            mem_write_enable  <= 1'b1;
            mem_to_write_data <= merged;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= mem_read_data;
          end
`else
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= mem_read_data;
`endif
        end
        S_WRITE: begin
          state            <= S_RESP;
          mem_write_enable <= 1'b0;
          resp_valid       <= 1'b1;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state            <= S_IDLE;
          mem_write_enable <= 1'b0;
          resp_valid       <= 1'b0;
          busy             <= 1'b0;
          req_ready        <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Scoreboard bench for vector_lsu with a registered-read memory model.
// Masked-store cases follow VLSU_MASKED_STORE_EN.
module tb_vector_lsu;

  typedef logic [3:0][31:0] vec_t;
  typedef struct {
    vec_t rd;
    int   lat;
    int   we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  vec_t        req_wdata = '0;
  logic [3:0]  req_mask = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  vec_t        resp_rdata;
  logic        busy;
  logic        mem_write_enable;
  logic [31:0] mem_data_adr;
  vec_t        mem_to_write_data;
  vec_t        mem_read_data;

  vec_t        mem [0:63];
  int          we_cnt = 0;
  logic [31:0] we_adr = '0;
  exp_t        sb_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  vector_lsu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_mask          (req_mask),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_rdata        (resp_rdata),
    .busy              (busy),
    .mem_write_enable  (mem_write_enable),
    .mem_data_adr      (mem_data_adr),
    .mem_to_write_data (mem_to_write_data),
    .mem_read_data     (mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_enable) mem[mem_data_adr[9:4]] <= mem_to_write_data;
    mem_read_data <= mem[mem_data_adr[9:4]];
  end

  always @(negedge clk) begin
    if (mem_write_enable === 1'b1) begin
      we_cnt <= we_cnt + 1;
      we_adr <= mem_data_adr;
    end
  end

  function automatic vec_t mkvec(input logic [31:0] a, b, c, d);
    vec_t v;
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    return v;
  endfunction

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic lsu_req(input logic wr, input logic [31:0] adr,
                         input vec_t wd, input logic [3:0] mk,
                         input vec_t exp_rd, input int exp_lat,
                         input int exp_we, input int hold);
    int   we0;
    int   lat;
    vec_t held;
    exp_t e;
    sb_q.push_back('{rd: exp_rd, lat: exp_lat, we: exp_we});
    we0 = we_cnt;
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = adr;
    req_wdata = wd; req_mask = mk;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e = sb_q.pop_front();
    check("latency", lat, e.lat);
    held = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0];
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, held);
      check("hold_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("rdata", held, e.rd);
    check("post_ready", req_ready, 1);
    check("post_valid", resp_valid, 0);
    check("we_cycles", we_cnt - we0, e.we);
  endtask

  initial begin
    int we0;
    mem[1] <= mkvec(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    mem[3] <= mkvec(1, 2, 3, 4);
    mem[4] <= mkvec(7, 7, 7, 7);
    mem[5] <= mkvec(5, 5, 5, 5);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_we", mem_write_enable, 0);
    check("rst_adr", mem_data_adr, 0);
    check("rst_wdata", mem_to_write_data, 0);

    lsu_req(0, 32'h10, '0, 4'h0,
            mkvec(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444),
            3, 0, 0);

    lsu_req(1, 32'h20, mkvec(32'hA, 32'hB, 32'hC, 32'hD), 4'hF, '0, 2, 1, 0);
    check("store_adr", we_adr, 32'h20);
    lsu_req(0, 32'h20, '0, 4'h0, mkvec(32'hA, 32'hB, 32'hC, 32'hD), 3, 0, 0);

`ifdef VLSU_MASKED_STORE_EN
    lsu_req(1, 32'h30, mkvec(32'hFF, 32'hFF, 32'hFF, 32'hFF), 4'b0101,
            '0, 4, 1, 0);
    check("masked_mem", mem[3], mkvec(32'hFF, 2, 32'hFF, 4));
    lsu_req(0, 32'h30, '0, 4'h0, mkvec(32'hFF, 2, 32'hFF, 4), 3, 0, 0);
    lsu_req(1, 32'h40, mkvec(9, 9, 9, 9), 4'b0000, '0, 1, 0, 0);
    check("zero_mask_mem", mem[4], mkvec(7, 7, 7, 7));
`else
    lsu_req(1, 32'h30, mkvec(32'hFF, 32'hFF, 32'hFF, 32'hFF), 4'b0101,
            '0, 2, 1, 0);
    check("nomask_mem", mem[3], mkvec(32'hFF, 32'hFF, 32'hFF, 32'hFF));
    lsu_req(1, 32'h40, mkvec(9, 9, 9, 9), 4'b0000, '0, 2, 1, 0);
    check("nomask_zero_mem", mem[4], mkvec(9, 9, 9, 9));
`endif

    lsu_req(0, 32'h10, '0, 4'h0,
            mkvec(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444),
            3, 0, 5);

    we0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h50;
    req_wdata = mkvec(6, 6, 6, 6); req_mask = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_we_high", mem_write_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_we_low", mem_write_enable, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_we_cnt", we_cnt - we0, 0);
    check("abort_mem", mem[5], mkvec(5, 5, 5, 5));
    check("abort_ready", req_ready, 1);
    check("abort_valid", resp_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_rdata", resp_rdata, 0);
    check("abort_adr", mem_data_adr, 0);
    check("abort_wdata", mem_to_write_data, 0);

    lsu_req(0, 32'h20, '0, 4'h0, mkvec(32'hA, 32'hB, 32'hC, 32'hD), 3, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
